// File: rtl/rob.sv
// rob: reorder buffer. Allocates entries in issue order, captures rs/lsb
// broadcasts and retires one entry per cycle into the regfile or LSB. When
// a retiring branch was mispredicted, it flushes the whole pipeline.
// Ports:
//   clk_in, rst_in (async, active low), rdy_in (stall)
//   dec_*    : issue request; rob_full / tail_id go back to the decoder
//   rs_*/lsb_*: result broadcasts
//   qj_*/qk_*: operand queries
//   commit_* : retire outputs
//   clear, clear_pc: flush on mispredict
// Macro ROB_CDB_BYPASS_EN: queries also see a broadcast in the same cycle.
module rob #(
  parameter int          ROB_WIDTH = 3,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 dec_valid,
  input  logic [1:0]           dec_type,
  input  logic [4:0]           dec_rd,
  input  logic [31:0]          dec_pred_pc,
  output logic                 rob_full,
  output logic [ROB_WIDTH-1:0] tail_id,
  input  logic                 rs_ready,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_value,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  input  logic [ROB_WIDTH-1:0] qj_id,
  input  logic [ROB_WIDTH-1:0] qk_id,
  output logic                 qj_ready,
  output logic                 qk_ready,
  output logic [31:0]          qj_value,
  output logic [31:0]          qk_value,
  output logic                 commit_valid,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 commit_reg_we,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_value,
  output logic                 commit_store,
  output logic                 clear,
  output logic [31:0]          clear_pc
);
  localparam int SIZE = 1 << ROB_WIDTH;
  localparam logic [1:0] T_REG  = 2'd0;
  localparam logic [1:0] T_BR   = 2'd1;
  localparam logic [1:0] T_ST   = 2'd2;
  localparam logic [1:0] T_DONE = 2'd3;
  localparam logic [ROB_WIDTH-1:0] P_ONE = ROB_WIDTH'(1);
  localparam logic [ROB_WIDTH:0] C_ONE = (ROB_WIDTH+1)'(1);
  localparam logic [ROB_WIDTH:0] C_FULL = (ROB_WIDTH+1)'(SIZE);

  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;
  logic [SIZE-1:0]      r_busy;
  logic [SIZE-1:0]      r_rdy;
  logic [1:0]           r_type [SIZE];
  logic [4:0]           r_rd   [SIZE];
  logic [31:0]          r_pred [SIZE];
  logic [31:0]          r_val  [SIZE];

  logic        w_head_rs;
  logic        w_head_lsb;
  logic        w_head_rdy;
  logic [31:0] w_head_val;
  logic        w_commit;
  logic        w_mispred;
  logic        w_issue;
  logic        w_rs_wb;
  logic        w_lsb_wb;

  assign rob_full = (r_count == C_FULL);
  assign tail_id  = r_tail;

  // A broadcast aimed at the head retires it on the same edge
  assign w_head_rs  = rs_ready && (rs_rob_id == r_head);
  assign w_head_lsb = lsb_ready && (lsb_rob_id == r_head);
  assign w_head_rdy = r_rdy[r_head] | w_head_rs | w_head_lsb;
  assign w_head_val = r_rdy[r_head] ? r_val[r_head] :
                      w_head_rs     ? rs_value :
                      w_head_lsb    ? lsb_value : r_val[r_head];

  assign w_commit  = rdy_in && !clear && r_busy[r_head] && w_head_rdy;
  assign w_mispred = w_commit && (r_type[r_head] == T_BR) &&
                     (w_head_val != r_pred[r_head]);
  // When full, the slot freed by this cycle's commit is the tail slot
  assign w_issue   = rdy_in && dec_valid && !clear && !w_mispred &&
                     (!rob_full || w_commit);
  assign w_rs_wb   = rdy_in && rs_ready && r_busy[rs_rob_id];
  assign w_lsb_wb  = rdy_in && lsb_ready && r_busy[lsb_rob_id];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_busy        <= '0;
      r_rdy         <= '0;
      commit_valid  <= 1'b0;
      commit_rob_id <= '0;
      commit_reg_we <= 1'b0;
      commit_rd     <= '0;
      commit_value  <= '0;
      commit_store  <= 1'b0;
      clear         <= 1'b0;
      clear_pc      <= PC_RESET;
    end else if (rdy_in) begin
      commit_valid  <= 1'b0;
      commit_reg_we <= 1'b0;
      commit_store  <= 1'b0;
      clear         <= 1'b0;
      if (w_rs_wb) r_rdy[rs_rob_id] <= 1'b1;
      if (w_lsb_wb) r_rdy[lsb_rob_id] <= 1'b1;
      if (w_commit) begin
        r_busy[r_head] <= 1'b0;
        r_rdy[r_head]  <= 1'b0;
        r_head         <= r_head + P_ONE;
        commit_valid   <= 1'b1;
        commit_rob_id  <= r_head;
        commit_reg_we  <= (r_type[r_head] == T_REG) &&
                          (r_rd[r_head] != 5'd0);
        commit_rd      <= r_rd[r_head];
        commit_value   <= w_head_val;
        commit_store   <= (r_type[r_head] == T_ST);
      end
      if (w_issue) begin
        r_busy[r_tail] <= 1'b1;
        r_rdy[r_tail]  <= (dec_type == T_DONE);
        r_tail         <= r_tail + P_ONE;
      end
      unique case ({w_issue, w_commit})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: ;
      endcase
      if (w_mispred) begin
        r_busy   <= '0;
        r_rdy    <= '0;
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
        clear    <= 1'b1;
        clear_pc <= w_head_val;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_rs_wb) r_val[rs_rob_id] <= rs_value;
    if (w_lsb_wb) r_val[lsb_rob_id] <= lsb_value;
    if (w_issue) begin
      r_type[r_tail] <= dec_type;
      r_rd[r_tail]   <= dec_rd;
      r_pred[r_tail] <= dec_pred_pc;
      r_val[r_tail]  <= '0;
    end
  end

  function automatic logic [32:0] f_query(
    input logic [ROB_WIDTH-1:0] id
  );
    logic [32:0] res;
    res = '0;
    if (r_busy[id]) begin
      if (r_rdy[id]) res = {1'b1, r_val[id]};
`ifdef ROB_CDB_BYPASS_EN
      if (rs_ready && rs_rob_id == id)
        res = {1'b1, rs_value};
      else if (lsb_ready && lsb_rob_id == id)
        res = {1'b1, lsb_value};
`endif
    end
    return res;
  endfunction

  assign {qj_ready, qj_value} = f_query(qj_id);
  assign {qk_ready, qk_value} = f_query(qk_id);
endmodule

// File: tb/tb_rob.sv
// tb_rob: self-checking bench for the reorder buffer against an in-order
// queue model of live instructions.
module tb_rob;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        dec_valid = 1'b0;
  logic [1:0]  dec_type = 2'd0;
  logic [4:0]  dec_rd = 5'd0;
  logic [31:0] dec_pred_pc = 32'd0;
  logic        rob_full;
  logic [2:0]  tail_id;
  logic        rs_ready = 1'b0;
  logic [2:0]  rs_rob_id = 3'd0;
  logic [31:0] rs_value = 32'd0;
  logic        lsb_ready = 1'b0;
  logic [2:0]  lsb_rob_id = 3'd0;
  logic [31:0] lsb_value = 32'd0;
  logic [2:0]  qj_id = 3'd0;
  logic [2:0]  qk_id = 3'd0;
  logic        qj_ready, qk_ready;
  logic [31:0] qj_value, qk_value;
  logic        commit_valid;
  logic [2:0]  commit_rob_id;
  logic        commit_reg_we;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic        commit_store;
  logic        clear;
  logic [31:0] clear_pc;

  rob dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_valid(dec_valid), .dec_type(dec_type), .dec_rd(dec_rd),
    .dec_pred_pc(dec_pred_pc), .rob_full(rob_full), .tail_id(tail_id),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id),
    .lsb_value(lsb_value), .qj_id(qj_id), .qk_id(qk_id),
    .qj_ready(qj_ready), .qk_ready(qk_ready),
    .qj_value(qj_value), .qk_value(qk_value),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .commit_reg_we(commit_reg_we), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_store(commit_store),
    .clear(clear), .clear_pc(clear_pc)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [2:0]  id;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pred;
    logic        rdy;
    logic [31:0] val;
  } ent_t;

  ent_t        q[$];
  logic [2:0]  m_tail;
  logic        e_cv, e_we, e_st, e_clr;
  logic [2:0]  e_id;
  logic [4:0]  e_rd;
  logic [31:0] e_val, e_cpc;

  task automatic model_reset();
    q.delete();
    m_tail = 3'd0;
    e_cv = 0; e_we = 0; e_st = 0; e_clr = 0;
    e_id = 3'd0; e_rd = 5'd0; e_val = 32'd0; e_cpc = 32'd0;
  endtask

  // One clock edge of the ROB, described as an ordered list of live insts
  task automatic model_step();
    logic clr_prev, mis;
    ent_t e;
    if (!rst_in) begin model_reset(); return; end
    if (!rdy_in) return;
    clr_prev = e_clr;
    e_cv = 0; e_we = 0; e_st = 0; e_clr = 0;
    if (clr_prev) return;
    foreach (q[i]) begin
      if (rs_ready && q[i].id == rs_rob_id) begin
        q[i].rdy = 1'b1; q[i].val = rs_value;
      end
      if (lsb_ready && q[i].id == lsb_rob_id) begin
        q[i].rdy = 1'b1; q[i].val = lsb_value;
      end
    end
    mis = 0;
    if (q.size() > 0 && q[0].rdy) begin
      e = q.pop_front();
      e_cv = 1; e_id = e.id; e_rd = e.rd; e_val = e.val;
      e_we = (e.typ == 2'd0) && (e.rd != 5'd0);
      e_st = (e.typ == 2'd2);
      if (e.typ == 2'd1 && e.val != e.pred) begin
        mis = 1; e_clr = 1; e_cpc = e.val;
        q.delete(); m_tail = 3'd0;
      end
    end
    if (dec_valid && !mis && q.size() < 8) begin
      e.id = m_tail; e.typ = dec_type; e.rd = dec_rd;
      e.pred = dec_pred_pc; e.rdy = (dec_type == 2'd3); e.val = 32'd0;
      q.push_back(e);
      m_tail = m_tail + 3'd1;
    end
  endtask

  task automatic m_query(input logic [2:0] id, output logic r,
                         output logic [31:0] v);
    r = 0; v = 32'd0;
    foreach (q[i]) begin
      if (q[i].id == id) begin
        if (q[i].rdy) begin r = 1; v = q[i].val; end
`ifdef ROB_CDB_BYPASS_EN
        if (rs_ready && rs_rob_id == id) begin
          r = 1; v = rs_value;
        end else if (lsb_ready && lsb_rob_id == id) begin
          r = 1; v = lsb_value;
        end
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; rs_ready = 0; lsb_ready = 0; rdy_in = 1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd,
                       input logic [31:0] p);
    dec_valid = 1; dec_type = t; dec_rd = rd; dec_pred_pc = p;
    tick();
    dec_valid = 0;
  endtask

  task automatic bc_rs(input logic [2:0] id, input logic [31:0] v);
    rs_ready = 1; rs_rob_id = id; rs_value = v;
    tick();
    rs_ready = 0;
  endtask

  task automatic bc_lsb(input logic [2:0] id, input logic [31:0] v);
    lsb_ready = 1; lsb_rob_id = id; lsb_value = v;
    tick();
    lsb_ready = 0;
  endtask

  task automatic test_reset();
    idle(); rst_in = 0;
    tick(); tick();
    rst_in = 1;
    n_chk++; if (commit_valid !== 1'b0 || clear !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses got cv=%0b clr=%0b exp 0 0", commit_valid, clear); end
    n_chk++; if (clear_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_clear_pc got=%h exp=0", clear_pc); end
    n_chk++; if (rob_full !== 1'b0 || tail_id !== 3'd0) begin
      n_fail++; $display("FAIL reset_ptr got full=%0b tail=%0d exp 0 0", rob_full, tail_id); end
    for (int i = 0; i < 5; i++) issue(2'd0, 5'(i + 1), 32'd0);
    bc_rs(3'd0, 32'h11);
    n_chk++; if (commit_valid !== e_cv || commit_value !== 32'h11) begin
      n_fail++; $display("FAIL reset_pre_cv got=%0b/%h exp=%0b/11", commit_valid, commit_value, e_cv); end
    #3 rst_in = 0;
    #1;
    n_chk++; if (commit_valid !== 1'b0 || commit_value !== 32'd0 ||
                 commit_rd !== 5'd0 || commit_reg_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_commit got cv=%0b v=%h rd=%0d we=%0b exp all 0", commit_valid, commit_value, commit_rd, commit_reg_we); end
    n_chk++; if (rob_full !== 1'b0 || tail_id !== 3'd0 || qj_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_ptr got full=%0b tail=%0d qj=%0b exp 0 0 0", rob_full, tail_id, qj_ready); end
    tick();
    rst_in = 1;
  endtask

  task automatic test_fill_wrap();
    logic [2:0] t0;
    for (int i = 0; i < 8; i++) issue(2'd0, 5'(i + 1), 32'd0);
    n_chk++; if (rob_full !== 1'b1 || tail_id !== m_tail) begin
      n_fail++; $display("FAIL fill_full got full=%0b tail=%0d exp 1 %0d", rob_full, tail_id, m_tail); end
    t0 = tail_id;
    issue(2'd0, 5'd9, 32'd0);
    n_chk++; if (rob_full !== 1'b1 || tail_id !== t0 || q.size() != 8) begin
      n_fail++; $display("FAIL fill_drop9 got full=%0b tail=%0d exp 1 %0d", rob_full, tail_id, t0); end
    for (int i = 0; i < 8; i++) begin
      bc_rs(3'(i), 32'(i * 3));
      n_chk++; if (commit_valid !== 1'b1 || commit_rob_id !== 3'(i) ||
                   commit_value !== 32'(i * 3) || commit_rd !== 5'(i + 1) ||
                   commit_reg_we !== 1'b1) begin
        n_fail++; $display("FAIL fill_commit%0d got cv=%0b id=%0d v=%0d rd=%0d we=%0b exp 1 %0d %0d %0d 1",
                           i, commit_valid, commit_rob_id, commit_value, commit_rd, commit_reg_we, i, i * 3, i + 1); end
    end
    tick();
    n_chk++; if (commit_valid !== 1'b0 || rob_full !== 1'b0) begin
      n_fail++; $display("FAIL fill_drained got cv=%0b full=%0b exp 0 0", commit_valid, rob_full); end
  endtask

  task automatic test_ooo();
    logic [2:0] b;
    b = m_tail;
    for (int i = 0; i < 3; i++) issue(2'd0, 5'(10 + i), 32'd0);
    bc_rs(b + 3'd2, 32'hA2);
    n_chk++; if (commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL ooo_wait2 got cv=%0b exp 0", commit_valid); end
    bc_lsb(b + 3'd1, 32'hA1);
    n_chk++; if (commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL ooo_wait1 got cv=%0b exp 0", commit_valid); end
    bc_rs(b, 32'hA0);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (commit_valid !== 1'b1 || commit_rob_id !== b + 3'(i) ||
                   commit_value !== e_val) begin
        n_fail++; $display("FAIL ooo_commit%0d got cv=%0b id=%0d v=%h exp 1 %0d %h", i, commit_valid, commit_rob_id, commit_value, b + 3'(i), e_val); end
      tick();
    end
    n_chk++; if (commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL ooo_end got cv=%0b exp 0", commit_valid); end
  endtask

  task automatic test_mispredict();
    logic [2:0] b;
    b = m_tail;
    issue(2'd1, 5'd0, 32'h100);
    for (int i = 0; i < 3; i++) issue(2'd0, 5'(20 + i), 32'd0);
    for (int i = 1; i < 4; i++) bc_lsb(b + 3'(i), 32'(i));
    n_chk++; if (commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL mis_wait got cv=%0b exp 0", commit_valid); end
    bc_rs(b, 32'h200);
    n_chk++; if (commit_valid !== 1'b1 || commit_rob_id !== b ||
                 clear !== 1'b1 || clear_pc !== 32'h200) begin
      n_fail++; $display("FAIL mis_clear got cv=%0b id=%0d clr=%0b pc=%h exp 1 %0d 1 200", commit_valid, commit_rob_id, clear, clear_pc, b); end
    issue(2'd0, 5'd7, 32'd0);
    n_chk++; if (clear !== 1'b0 || commit_valid !== 1'b0 ||
                 tail_id !== 3'd0 || rob_full !== 1'b0) begin
      n_fail++; $display("FAIL mis_after got clr=%0b cv=%0b tail=%0d full=%0b exp 0 0 0 0", clear, commit_valid, tail_id, rob_full); end
    tick(); tick();
    n_chk++; if (commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL mis_young got cv=%0b exp 0", commit_valid); end
    issue(2'd1, 5'd0, 32'h40);
    bc_rs(3'd0, 32'h40);
    n_chk++; if (commit_valid !== 1'b1 || clear !== 1'b0) begin
      n_fail++; $display("FAIL br_ok got cv=%0b clr=%0b exp 1 0", commit_valid, clear); end
  endtask

  task automatic test_store_rd0();
    logic [2:0] b;
    b = m_tail;
    issue(2'd2, 5'd3, 32'd0);
    issue(2'd0, 5'd0, 32'd0);
    issue(2'd3, 5'd4, 32'd0);
    bc_lsb(b, 32'h5);
    n_chk++; if (commit_valid !== 1'b1 || commit_store !== 1'b1 ||
                 commit_reg_we !== 1'b0) begin
      n_fail++; $display("FAIL store got cv=%0b st=%0b we=%0b exp 1 1 0", commit_valid, commit_store, commit_reg_we); end
    bc_rs(b + 3'd1, 32'h77);
    n_chk++; if (commit_valid !== 1'b1 || commit_reg_we !== 1'b0 ||
                 commit_store !== 1'b0 || commit_value !== 32'h77) begin
      n_fail++; $display("FAIL rd0 got cv=%0b we=%0b st=%0b v=%h exp 1 0 0 77", commit_valid, commit_reg_we, commit_store, commit_value); end
    tick();
    n_chk++; if (commit_valid !== 1'b1 || commit_rob_id !== b + 3'd2 ||
                 commit_reg_we !== 1'b0) begin
      n_fail++; $display("FAIL done got cv=%0b id=%0d we=%0b exp 1 %0d 0", commit_valid, commit_rob_id, commit_reg_we, b + 3'd2); end
  endtask

  task automatic test_full_issue_commit();
    for (int i = 0; i < 8; i++) issue(2'd0, 5'(i + 1), 32'd0);
    dec_valid = 1; dec_type = 2'd0; dec_rd = 5'd5;
    rs_ready = 1; rs_rob_id = q[0].id; rs_value = 32'h99;
    tick();
    idle();
    n_chk++; if (commit_valid !== 1'b1 || rob_full !== 1'b1 ||
                 tail_id !== m_tail || q.size() != 8) begin
      n_fail++; $display("FAIL full_swap got cv=%0b full=%0b tail=%0d exp 1 1 %0d", commit_valid, rob_full, tail_id, m_tail); end
    for (int i = 0; i < 8; i++) begin
      bc_rs(q[0].id, 32'(i));
      n_chk++; if (commit_valid !== 1'b1 || commit_rob_id !== e_id) begin
        n_fail++; $display("FAIL full_drain%0d got cv=%0b id=%0d exp 1 %0d", i, commit_valid, commit_rob_id, e_id); end
    end
    n_chk++; if (rob_full !== 1'b0) begin
      n_fail++; $display("FAIL full_empty got full=%0b exp 0", rob_full); end
  endtask

  task automatic test_bypass();
    logic r;
    logic [31:0] v;
    idle(); rst_in = 0; tick(); rst_in = 1;
    for (int i = 0; i < 5; i++) issue(2'd0, 5'(i + 1), 32'd0);
    qj_id = 3'd4; qk_id = 3'd6;
    rs_ready = 1; rs_rob_id = 3'd4; rs_value = 32'h55;
    #1;
    m_query(3'd4, r, v);
    n_chk++; if (qj_ready !== r || qj_value !== v) begin
      n_fail++; $display("FAIL bypass_same got r=%0b v=%h exp %0b %h", qj_ready, qj_value, r, v); end
    n_chk++; if (qk_ready !== 1'b0 || qk_value !== 32'd0) begin
      n_fail++; $display("FAIL query_free got r=%0b v=%h exp 0 0", qk_ready, qk_value); end
    tick();
    rs_ready = 0;
    #1;
    n_chk++; if (qj_ready !== 1'b1 || qj_value !== 32'h55) begin
      n_fail++; $display("FAIL bypass_next got r=%0b v=%h exp 1 55", qj_ready, qj_value); end
  endtask

  function automatic logic [31:0] res_val(input ent_t e);
    if (e.typ == 2'd1)
      return ($urandom_range(0, 3) == 0) ? e.pred + 32'd4 : e.pred;
    return $urandom;
  endfunction

  task automatic test_random();
    int nr[$];
    logic [2:0] fr[$];
    int k;
    logic r;
    logic [31:0] v;
    bit used;
    for (int cyc = 0; cyc < 800; cyc++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      dec_valid = ($urandom_range(0, 2) != 0);
      dec_type = 2'($urandom_range(0, 3));
      dec_rd = 5'($urandom_range(0, 31));
      dec_pred_pc = 32'($urandom_range(0, 15)) << 2;
      rs_ready = 0; lsb_ready = 0;
      nr.delete(); fr.delete();
      foreach (q[i]) if (!q[i].rdy) nr.push_back(i);
      for (int id = 0; id < 8; id++) begin
        used = 0;
        foreach (q[i]) if (q[i].id == 3'(id)) used = 1;
        if (!used) fr.push_back(3'(id));
      end
      if (nr.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, nr.size() - 1);
        rs_ready = 1; rs_rob_id = q[nr[k]].id; rs_value = res_val(q[nr[k]]);
        nr.delete(k);
      end
      if (nr.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, nr.size() - 1);
        lsb_ready = 1; lsb_rob_id = q[nr[k]].id;
        lsb_value = res_val(q[nr[k]]);
      end else if (fr.size() > 0 && $urandom_range(0, 5) == 0) begin
        lsb_ready = 1; lsb_value = $urandom;
        lsb_rob_id = fr[$urandom_range(0, fr.size() - 1)];
      end
      qj_id = 3'($urandom_range(0, 7));
      qk_id = 3'($urandom_range(0, 7));
      #1;
      m_query(qj_id, r, v);
      n_chk++; if (qj_ready !== r || qj_value !== v) begin
        n_fail++; $display("FAIL rnd_qj c%0d got %0b/%h exp %0b/%h", cyc, qj_ready, qj_value, r, v); end
      m_query(qk_id, r, v);
      n_chk++; if (qk_ready !== r || qk_value !== v) begin
        n_fail++; $display("FAIL rnd_qk c%0d got %0b/%h exp %0b/%h", cyc, qk_ready, qk_value, r, v); end
      tick();
      n_chk++; if (commit_valid !== e_cv || commit_rob_id !== e_id ||
                   commit_reg_we !== e_we || commit_rd !== e_rd ||
                   commit_value !== e_val || commit_store !== e_st) begin
        n_fail++; $display("FAIL rnd_commit c%0d got %0b %0d %0b %0d %h %0b exp %0b %0d %0b %0d %h %0b", cyc,
                           commit_valid, commit_rob_id, commit_reg_we, commit_rd, commit_value, commit_store,
                           e_cv, e_id, e_we, e_rd, e_val, e_st); end
      n_chk++; if (clear !== e_clr || clear_pc !== e_cpc) begin
        n_fail++; $display("FAIL rnd_clear c%0d got %0b/%h exp %0b/%h", cyc, clear, clear_pc, e_clr, e_cpc); end
      n_chk++; if (rob_full !== (q.size() == 8) || tail_id !== m_tail) begin
        n_fail++; $display("FAIL rnd_ptr c%0d got full=%0b tail=%0d exp %0b %0d", cyc, rob_full, tail_id, q.size() == 8, m_tail); end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_wrap();
    test_ooo();
    test_mispredict();
    test_store_rd0();
    test_full_issue_commit();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
